hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 19 +
 rtl/hazard_unit_fwd_select.sv | 24 ++
 rtl/hazard_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_unit_pkg;

    // Multiply/divide unit sequencing states
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    // ALU operand forward-select encodings
    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_W    = 2'b01;
    localparam logic [1:0] FW_M    = 2'b10;

    // Width of the multiply/divide busy counter (covers 1..63 cycles)
    localparam int CNT_W = 6;

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Forwarding source select for one ALU operand; MEM stage wins over WB.
module fwd_select
    import hazard_unit_pkg::*;
(
    input  logic [4:0] src_addr,
    input  logic [4:0] mem_addr,
    input  logic       mem_write,
    input  logic [4:0] wb_addr,
    input  logic       wb_write,
    output logic [1:0] sel
);

    // Pick the youngest in-flight producer of src_addr; r0 is never forwarded
    always_comb begin
        sel = FW_NONE;
        if (wb_write && (wb_addr != 5'd0) && (wb_addr == src_addr)) begin
            sel = FW_W;
        end
        if (mem_write && (mem_addr != 5'd0) && (mem_addr == src_addr)) begin
            sel = FW_M;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use / multiply-divide stalls,
// branch flushes, multiply/divide busy tracking and a stall counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addrD,
    input  logic [4:0]  rt_addrD,
    input  logic [4:0]  rs_addrE,
    input  logic [4:0]  rt_addrE,
    input  logic [4:0]  write_reg_addrE,
    input  logic [4:0]  write_reg_addrM,
    input  logic [4:0]  write_reg_addrW,
    input  logic        reg_writeE,
    input  logic        reg_writeM,
    input  logic        reg_writeW,
    input  logic        mem_to_regE,
    input  logic        branch_takenE,
    input  logic        md_startE,
    input  logic        md_divE,
    input  logic        md_useD,
    output logic [1:0]  fw_alu1,
    output logic [1:0]  fw_alu2,
    output logic        stallF,
    output logic        stallD,
    output logic        flushD,
    output logic        flushE,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_overlap_err,
    output logic [15:0] stall_cycles
);

    // Counter reload values: the counter runs N-1 down to 0, giving N busy cycles
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic [15:0]      stall_cnt_reg;

    logic load_use;
    logic md_hazard;
    logic hazard;
    logic md_start_ok;

    fwd_select u_fwd_a (
        .src_addr  (rs_addrE),
        .mem_addr  (write_reg_addrM),
        .mem_write (reg_writeM),
        .wb_addr   (write_reg_addrW),
        .wb_write  (reg_writeW),
        .sel       (fw_alu1)
    );

    fwd_select u_fwd_b (
        .src_addr  (rt_addrE),
        .mem_addr  (write_reg_addrM),
        .mem_write (reg_writeM),
        .wb_addr   (write_reg_addrW),
        .wb_write  (reg_writeW),
        .sel       (fw_alu2)
    );

    assign md_busy        = (state_reg == MD_BUSY);
    assign md_done        = (state_reg == MD_DONE);
    assign md_overlap_err = err_reg;
    assign stall_cycles   = stall_cnt_reg;

    // A flushed EX instruction must not launch the multiply/divide unit
    assign md_start_ok = md_startE & ~branch_takenE;

    // Stall/flush decisions; a taken branch discards the stalled instruction anyway
    always_comb begin
        load_use  = mem_to_regE && reg_writeE && (write_reg_addrE != 5'd0) &&
                    ((write_reg_addrE == rs_addrD) || (write_reg_addrE == rt_addrD));
        md_hazard = md_useD && (md_busy || md_startE);
        hazard    = load_use || md_hazard;
        stallF    = hazard && !branch_takenE;
        stallD    = hazard && !branch_takenE;
        flushD    = branch_takenE;
        flushE    = hazard || branch_takenE;
    end

    // Multiply/divide sequencing and overlap detection
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            MD_IDLE, MD_DONE: begin
                if (md_start_ok) begin
                    state_next = MD_BUSY;
                    cnt_next   = md_divE ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_next = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (md_startE) begin
                    err_next = 1'b1;
                end
                if (cnt_reg == '0) begin
                    state_next = MD_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = MD_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Saturating count of cycles spent with the decode stage held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'd0;
        end else if (stallD && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: per-cycle model comparison plus
// directed scenarios with hand-computed expectations.
module tb_hazard_unit;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_addrD, rt_addrD, rs_addrE, rt_addrE;
    logic [4:0]  write_reg_addrE, write_reg_addrM, write_reg_addrW;
    logic        reg_writeE, reg_writeM, reg_writeW;
    logic        mem_to_regE, branch_takenE, md_startE, md_divE, md_useD;
    logic [1:0]  fw_alu1, fw_alu2;
    logic        stallF, stallD, flushD, flushE;
    logic        md_busy, md_done, md_overlap_err;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addrD(rs_addrD), .rt_addrD(rt_addrD),
        .rs_addrE(rs_addrE), .rt_addrE(rt_addrE),
        .write_reg_addrE(write_reg_addrE), .write_reg_addrM(write_reg_addrM),
        .write_reg_addrW(write_reg_addrW),
        .reg_writeE(reg_writeE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .mem_to_regE(mem_to_regE), .branch_takenE(branch_takenE),
        .md_startE(md_startE), .md_divE(md_divE), .md_useD(md_useD),
        .fw_alu1(fw_alu1), .fw_alu2(fw_alu2),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .md_busy(md_busy), .md_done(md_done), .md_overlap_err(md_overlap_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_rem    = 0;   // busy cycles still to come, including the current one
    bit m_done   = 0;
    bit m_err    = 0;
    int m_stalls = 0;

    function automatic logic [1:0] exp_fw(input logic [4:0] src);
        if (reg_writeM && write_reg_addrM != 0 && write_reg_addrM == src) return 2'b10;
        if (reg_writeW && write_reg_addrW != 0 && write_reg_addrW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_hazard();
        bit lu, mh;
        lu = mem_to_regE && reg_writeE && write_reg_addrE != 0 &&
             (write_reg_addrE == rs_addrD || write_reg_addrE == rt_addrD);
        mh = md_useD && ((m_rem > 0) || md_startE);
        return lu || mh;
    endfunction

    function automatic bit exp_stall();
        return exp_hazard() && !branch_takenE;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_done = 0; m_err = 0; m_stalls = 0;
        end else begin
            bit st;
            st = exp_stall();
            if (m_rem > 0) begin
                if (md_startE) m_err = 1;
                m_rem--;
                m_done = (m_rem == 0);
            end else begin
                m_done = 0;
                if (md_startE && !branch_takenE) m_rem = md_divE ? DIV_N : MULT_N;
            end
            if (st && m_stalls < 65535) m_stalls++;
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        check("m_fw_alu1", fw_alu1, exp_fw(rs_addrE));
        check("m_fw_alu2", fw_alu2, exp_fw(rt_addrE));
        check("m_stallF", stallF, exp_stall());
        check("m_stallD", stallD, exp_stall());
        check("m_flushD", flushD, branch_takenE);
        check("m_flushE", flushE, exp_hazard() || branch_takenE);
        check("m_md_busy", md_busy, m_rem > 0);
        check("m_md_done", md_done, m_done);
        check("m_overlap", md_overlap_err, m_err);
        check("m_stall_cycles", stall_cycles, m_stalls[15:0]);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_addrD = 0; rt_addrD = 0; rs_addrE = 0; rt_addrE = 0;
        write_reg_addrE = 0; write_reg_addrM = 0; write_reg_addrW = 0;
        reg_writeE = 0; reg_writeM = 0; reg_writeW = 0;
        mem_to_regE = 0; branch_takenE = 0;
        md_startE = 0; md_divE = 0; md_useD = 0;
    endtask

    task automatic set_load_use();
        mem_to_regE = 1; reg_writeE = 1; write_reg_addrE = 5'd8; rt_addrD = 5'd8;
    endtask

    initial begin
        int n;
        int dones;
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        check("reset_busy", md_busy, 0);
        check("reset_done", md_done, 0);
        check("reset_err", md_overlap_err, 0);
        check("reset_stall_cycles", stall_cycles, 0);
        rst_n = 1'b1;
        tick();

        // Forwarding
        rs_addrE = 5; rt_addrE = 7;
        write_reg_addrM = 5; reg_writeM = 1; write_reg_addrW = 5; reg_writeW = 1;
        #2 check("fw_m_priority", fw_alu1, 2'b10);
        check("fw_alu2_none", fw_alu2, 2'b00);
        reg_writeM = 0;
        #1 check("fw_w_only", fw_alu1, 2'b01);
        rs_addrE = 0; rt_addrE = 0; write_reg_addrM = 0; write_reg_addrW = 0;
        reg_writeM = 1; reg_writeW = 1;
        #1 check("fw_r0_a", fw_alu1, 2'b00);
        check("fw_r0_b", fw_alu2, 2'b00);
        tick();
        clear_inputs();

        // Load-use: one stall cycle
        tick();
        set_load_use();
        #2 check("lu_stallF", stallF, 1);
        check("lu_stallD", stallD, 1);
        check("lu_flushE", flushE, 1);
        tick();
        clear_inputs();
        #2 check("lu_released", stallD, 0);
        check("lu_stall_cycles", stall_cycles, 1);

        // Branch overrides stall
        tick();
        set_load_use();
        branch_takenE = 1;
        #2 check("br_flushD", flushD, 1);
        check("br_flushE", flushE, 1);
        check("br_stallF", stallF, 0);
        check("br_stallD", stallD, 0);
        tick();
        clear_inputs();
        #2 check("br_stall_cycles", stall_cycles, 1);

        // Divide with dependent instruction waiting in ID
        tick();
        md_startE = 1; md_divE = 1; md_useD = 1;
        #2 check("div_start_stall", stallD, 1);
        tick();
        md_startE = 0; md_divE = 0;
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            if (stallD !== 1'b1) check("div_busy_stall", stallD, 1);
            tick();
        end
        check("div_busy_len", n, DIV_N);
        check("div_done", md_done, 1);
        check("div_done_nostall", stallD, 0);
        check("div_stall_cycles", stall_cycles, 34);
        md_useD = 0;
        tick();
        check("div_done_one", md_done, 0);

        // Overlap: second start at BUSY cycle 2 is ignored but flagged
        md_startE = 1; md_divE = 0;
        tick();
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            if (n == 2) begin md_startE = 1; md_divE = 1; end
            else md_startE = 0;
            tick();
        end
        md_startE = 0; md_divE = 0;
        check("ovl_no_extend", n, MULT_N);
        check("ovl_done", md_done, 1);
        check("ovl_err", md_overlap_err, 1);

        // Reset mid-BUSY aborts without a done pulse
        tick();
        md_startE = 1; md_divE = 1;
        tick();
        md_startE = 0; md_divE = 0;
        repeat (5) tick();
        check("rst_pre_busy", md_busy, 1);
        #1 rst_n = 1'b0;
        #1 check("rst_busy", md_busy, 0);
        check("rst_err", md_overlap_err, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done) dones++;
        end
        check("rst_no_done", dones, 0);

        // Stall counter saturation
        set_load_use();
        repeat (70000) tick();
        check("sat_stall_cycles", stall_cycles, 16'hFFFF);
        clear_inputs();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
